// File: rtl/bsg_test_node_pkg.sv
// Shared ring-word layout, FSM state encoding and word builder for the test-node master.
package bsg_test_node_pkg;

  localparam int unsigned ring_id_width_gp      = 4;
  localparam int unsigned ring_pad_width_gp     = 11;
  localparam int unsigned ring_payload_width_gp = 64;
  localparam int unsigned ring_width_gp         = ring_id_width_gp + ring_pad_width_gp
                                                + ring_payload_width_gp;

  typedef struct packed {
    logic [ring_id_width_gp-1:0]      id;
    logic [ring_pad_width_gp-1:0]     pad;
    logic [ring_payload_width_gp-1:0] payload;
  } bsg_test_node_ring_s;

  typedef enum logic [2:0] {
    eIdle,
    eSend,
    eRecv,
    eDone,
    eErr
  } bsg_test_node_master_state_e;

  // Builds a well-formed ring word (pad always zero).
  function automatic bsg_test_node_ring_s bsg_test_node_make_word(
    input logic [ring_id_width_gp-1:0]      id,
    input logic [ring_payload_width_gp-1:0] payload
  );
    bsg_test_node_ring_s w;
    w.id      = id;
    w.pad     = '0;
    w.payload = payload;
    return w;
  endfunction

endpackage

// File: rtl/bsg_test_node_if.sv
// Ring link between the test-node master and one client.
interface bsg_test_node_if #(
  parameter int unsigned ring_width_p = bsg_test_node_pkg::ring_width_gp
);

  logic                    en_o;
  logic                    v_o;
  logic [ring_width_p-1:0] data_o;
  logic                    ready_i;
  logic                    v_i;
  logic [ring_width_p-1:0] data_i;
  logic                    yumi_o;

  modport master (
    output en_o, v_o, data_o, yumi_o,
    input  ready_i, v_i, data_i
  );

  modport slave (
    input  en_o, v_o, data_o, yumi_o,
    output ready_i, v_i, data_i
  );

endinterface

// File: rtl/bsg_test_node_reply_checker.sv
// Reply datapath: accepts replies, checks the header, counts them and folds payloads into a checksum.
module bsg_test_node_reply_checker
  import bsg_test_node_pkg::*;
#(
  parameter int unsigned client_id_p = 0,
  parameter int unsigned num_resp_p  = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             clear_i,
  input  logic                             accept_en_i,
  input  logic                             v_i,
  input  bsg_test_node_ring_s              reply_i,
  output logic                             yumi_o,
  output logic                             full_c,
  output logic                             bad_c,
  output logic [ring_payload_width_gp-1:0] checksum_o
);

  localparam int unsigned resp_cnt_width_lp = $clog2(num_resp_p + 1);
  localparam logic [resp_cnt_width_lp-1:0] resp_target_lp = resp_cnt_width_lp'(num_resp_p);
  localparam logic [ring_id_width_gp-1:0]  client_id_lp   = ring_id_width_gp'(client_id_p);

  logic [resp_cnt_width_lp-1:0]     resp_cnt_q;
  logic [resp_cnt_width_lp-1:0]     resp_cnt_n;
  logic [ring_payload_width_gp-1:0] checksum_q;
  logic                             accept_c;
  logic                             excess_c;
  logic                             header_bad_c;

  // Accept/count/error decode; replies are always consumed so the client never stalls.
  always_comb begin
    accept_c     = v_i & accept_en_i;
    excess_c     = accept_c & (resp_cnt_q == resp_target_lp);
    header_bad_c = (reply_i.id != client_id_lp) | (reply_i.pad != '0);
    resp_cnt_n   = resp_cnt_q;
    if (accept_c & ~excess_c) begin
      resp_cnt_n = resp_cnt_q + resp_cnt_width_lp'(1);
    end
    bad_c  = accept_c & (header_bad_c | excess_c);
    full_c = (resp_cnt_n == resp_target_lp);
    yumi_o = v_i & reset_n_i;
  end

  // Reply count saturates at the target; excess replies still fold into the checksum.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_cnt_q <= '0;
      checksum_q <= '0;
    end else if (clear_i) begin
      resp_cnt_q <= '0;
      checksum_q <= '0;
    end else if (accept_c) begin
      resp_cnt_q <= resp_cnt_n;
      checksum_q <= checksum_q ^ reply_i.payload;
    end
  end

  assign checksum_o = checksum_q;

endmodule

// File: rtl/bsg_test_node_master.sv
// Test-node ring initiator: streams a command burst, then collects and checks the replies.
module bsg_test_node_master
  import bsg_test_node_pkg::*;
#(
  parameter int unsigned ring_width_p = ring_width_gp,
  parameter int unsigned master_id_p  = 0,
  parameter int unsigned client_id_p  = 0,
  parameter int unsigned num_words_p  = 16,
  parameter int unsigned num_resp_p   = 4,
  parameter logic [63:0] seed_p       = 64'h1,
  parameter int unsigned timeout_p    = 4096
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             start_i,
  bsg_test_node_if.master                  link,
  output logic                             done_o,
  output logic                             error_o,
  output logic [ring_payload_width_gp-1:0] checksum_o
);

  localparam int unsigned word_cnt_width_lp = $clog2(num_words_p + 1);
  localparam int unsigned idle_cnt_width_lp = $clog2(timeout_p);
  localparam logic [word_cnt_width_lp-1:0] last_word_lp  = word_cnt_width_lp'(num_words_p - 1);
  localparam logic [idle_cnt_width_lp-1:0] idle_limit_lp = idle_cnt_width_lp'(timeout_p - 1);
  localparam logic [ring_id_width_gp-1:0]  master_id_lp  = ring_id_width_gp'(master_id_p);

  bsg_test_node_master_state_e state_q, state_n;

  logic [word_cnt_width_lp-1:0] word_cnt_q;
  logic [idle_cnt_width_lp-1:0] idle_cnt_q;
  bsg_test_node_ring_s          data_q;
  logic                         done_q;
  logic                         error_q;

  bsg_test_node_ring_s          reply_c;
  logic [ring_width_gp-1:0]     reply_bits_c;
  logic                         start_ok_c;
  logic                         xfer_c;
  logic                         last_xfer_c;
  logic                         accept_en_c;
  logic                         timeout_c;
  logic                         resp_full_c;
  logic                         reply_bad_c;

  assign reply_bits_c = ring_width_gp'(link.data_i);
  assign reply_c      = bsg_test_node_ring_s'(reply_bits_c);

  // Control decode shared by the FSM and the datapath registers.
  always_comb begin
    start_ok_c  = start_i & ((state_q == eIdle) | (state_q == eDone) | (state_q == eErr));
    xfer_c      = (state_q == eSend) & link.ready_i;
    last_xfer_c = xfer_c & (word_cnt_q == last_word_lp);
    accept_en_c = (state_q == eSend) | (state_q == eRecv);
    timeout_c   = (state_q == eRecv) & ~link.v_i & ~resp_full_c & (idle_cnt_q == idle_limit_lp);
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eIdle;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic; reply completion wins over timeout.
  always_comb begin
    state_n = state_q;
    case (state_q)
      eIdle, eDone, eErr: if (start_i) state_n = eSend;
      eSend:              if (last_xfer_c) state_n = eRecv;
      eRecv: begin
        if (resp_full_c) begin
          state_n = eDone;
        end else if (timeout_c) begin
          state_n = eErr;
        end
      end
      default:            state_n = eIdle;
    endcase
  end

  // Link control outputs decoded from the registered state.
  always_comb begin
    link.en_o = 1'b0;
    link.v_o  = 1'b0;
    case (state_q)
      eSend: begin
        link.en_o = 1'b1;
        link.v_o  = 1'b1;
      end
      eRecv:   link.en_o = 1'b1;
      default: ;
    endcase
  end

  // Word generator, idle timer and sticky status flags.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      word_cnt_q <= '0;
      idle_cnt_q <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else if (start_ok_c) begin
      word_cnt_q <= '0;
      idle_cnt_q <= '0;
      data_q     <= bsg_test_node_make_word(master_id_lp, seed_p);
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (xfer_c) begin
        word_cnt_q     <= word_cnt_q + word_cnt_width_lp'(1);
        data_q.payload <= data_q.payload + ring_payload_width_gp'(1);
      end
      if (state_q == eRecv) begin
        idle_cnt_q <= link.v_i ? '0 : idle_cnt_q + idle_cnt_width_lp'(1);
      end
      if (reply_bad_c | timeout_c) begin
        error_q <= 1'b1;
      end
      if ((state_q == eRecv) & resp_full_c) begin
        done_q <= ~(error_q | reply_bad_c);
      end
    end
  end

  bsg_test_node_reply_checker #(
    .client_id_p (client_id_p),
    .num_resp_p  (num_resp_p)
  ) reply_checker (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .clear_i     (start_ok_c),
    .accept_en_i (accept_en_c),
    .v_i         (link.v_i),
    .reply_i     (reply_c),
    .yumi_o      (link.yumi_o),
    .full_c      (resp_full_c),
    .bad_c       (reply_bad_c),
    .checksum_o  (checksum_o)
  );

  assign link.data_o = ring_width_p'(data_q);
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_bsg_test_node_master.sv
// Randomized bench for the test-node master against a burst/reply reference model.
module tb_bsg_test_node_master;
  import bsg_test_node_pkg::*;

  localparam int unsigned MID  = 2;
  localparam int unsigned CID  = 0;
  localparam int unsigned NW   = 4;
  localparam int unsigned NR   = 4;
  localparam int unsigned TO   = 8;
  localparam logic [63:0] SEED = 64'd5;
  localparam int          BUDGET = 300;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        done;
  logic        error;
  logic [63:0] checksum;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bsg_test_node_if #(.ring_width_p(ring_width_gp)) link ();

  bsg_test_node_master #(
    .ring_width_p (ring_width_gp),
    .master_id_p  (MID),
    .client_id_p  (CID),
    .num_words_p  (NW),
    .num_resp_p   (NR),
    .seed_p       (SEED),
    .timeout_p    (TO)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .start_i    (start),
    .link       (link),
    .done_o     (done),
    .error_o    (error),
    .checksum_o (checksum)
  );

  always #5 clk = ~clk;

  // Observations collected by drive_run.
  bsg_test_node_ring_s reply_q[$];
  bsg_test_node_ring_s vo_word_q[$];
  bit                  vo_rdy_q[$];
  int                  vo_cyc_q[$];
  int                  last_reply_cyc;
  int                  end_cyc;
  bit                  err_fell;

  // Command word k of a burst.
  function automatic bsg_test_node_ring_s exp_word(input int k);
    bsg_test_node_ring_s w;
    w.id      = 4'(MID);
    w.pad     = '0;
    w.payload = SEED + 64'(k);
    return w;
  endfunction

  function automatic bsg_test_node_ring_s mk_reply(input logic [3:0] id, input logic [10:0] pad,
                                                   input logic [63:0] payload);
    bsg_test_node_ring_s w;
    w.id      = id;
    w.pad     = pad;
    w.payload = payload;
    return w;
  endfunction

  function automatic logic [63:0] rand64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  // Pulses start, then acts as the client until en_o drops or the budget runs out.
  task automatic drive_run(input int ready_mode, input int first_gap, input int max_gap,
                           input int stray_start);
    int gap;
    int cyc;
    bit seen_err;
    vo_word_q.delete();
    vo_rdy_q.delete();
    vo_cyc_q.delete();
    last_reply_cyc = -1;
    end_cyc        = -1;
    err_fell       = 1'b0;
    seen_err       = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    gap = first_gap;
    cyc = 0;
    while (cyc < BUDGET && end_cyc < 0) begin
      case (ready_mode)
        0:       link.ready_i = 1'b1;
        1:       link.ready_i = (cyc % 3 == 0);
        default: link.ready_i = 1'($urandom_range(1, 0));
      endcase
      start = (cyc == stray_start);
      if (reply_q.size() != 0 && gap == 0) begin
        link.v_i    = 1'b1;
        link.data_i = reply_q[0];
      end else begin
        link.v_i    = 1'b0;
        link.data_i = '0;
      end
      @(negedge clk);
      if (link.v_o) begin
        vo_word_q.push_back(link.data_o);
        vo_rdy_q.push_back(link.ready_i);
        vo_cyc_q.push_back(cyc);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (link.v_i) begin
        void'(reply_q.pop_front());
        last_reply_cyc = cyc;
        gap = $urandom_range(max_gap, 0);
      end else if (gap > 0) begin
        gap--;
      end
      if (error) seen_err = 1'b1;
      else if (seen_err) err_fell = 1'b1;
      if (!link.en_o) end_cyc = cyc;
      cyc++;
    end
    link.v_i     = 1'b0;
    link.ready_i = 1'b0;
    link.data_i  = '0;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    start        = 1'b0;
    link.ready_i = 1'b0;
    link.v_i     = 1'b0;
    link.data_i  = '0;
    #12;
    total_cnt++; if (link.en_o !== 1'b0) $display("FAIL reset_en: got %b expected 0", link.en_o); else pass_cnt++;
    total_cnt++; if (link.v_o !== 1'b0) $display("FAIL reset_v: got %b expected 0", link.v_o); else pass_cnt++;
    total_cnt++; if (link.data_o !== '0) $display("FAIL reset_data: got %h expected 0", link.data_o); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL reset_error: got %b expected 0", error); else pass_cnt++;
    total_cnt++; if (checksum !== 64'd0) $display("FAIL reset_checksum: got %h expected 0", checksum); else pass_cnt++;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (link.en_o !== 1'b0) $display("FAIL idle_en: got %b expected 0", link.en_o); else pass_cnt++;
  endtask

  task automatic test_basic();
    reply_q.delete();
    for (int i = 0; i < 4; i++) reply_q.push_back(mk_reply(4'(CID), 11'd0, 64'd1 << i));
    drive_run(0, 4, 0, -1);
    foreach (vo_word_q[i]) begin
      total_cnt++;
      if (vo_word_q[i] !== exp_word(i) || vo_cyc_q[i] !== i || vo_rdy_q[i] !== 1'b1)
        $display("FAIL basic_word%0d: got %h at cycle %0d expected %h at cycle %0d",
                 i, vo_word_q[i], vo_cyc_q[i], exp_word(i), i);
      else pass_cnt++;
    end
    total_cnt++; if (vo_word_q.size() !== 4) $display("FAIL basic_count: got %0d expected 4", vo_word_q.size()); else pass_cnt++;
    total_cnt++; if (checksum !== 64'd15) $display("FAIL basic_checksum: got %h expected f", checksum); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL basic_done: got %b expected 1", done); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL basic_error: got %b expected 0", error); else pass_cnt++;
    total_cnt++; if (end_cyc !== 7) $display("FAIL basic_done_cycle: got %0d expected 7", end_cyc); else pass_cnt++;
  endtask

  task automatic test_stall();
    logic [63:0] exp_cs;
    int xfers;
    reply_q.delete();
    exp_cs = '0;
    for (int i = 0; i < 4; i++) begin
      reply_q.push_back(mk_reply(4'(CID), 11'd0, rand64()));
      exp_cs ^= reply_q[i].payload;
    end
    drive_run(1, $urandom_range(12, 0), 3, -1);
    xfers = 0;
    foreach (vo_word_q[i]) begin
      total_cnt++;
      if (vo_word_q[i] !== exp_word(xfers) || vo_cyc_q[i] !== i)
        $display("FAIL stall_word_cyc%0d: got %h expected %h", vo_cyc_q[i], vo_word_q[i], exp_word(xfers));
      else pass_cnt++;
      if (vo_rdy_q[i]) xfers++;
    end
    total_cnt++; if (xfers !== 4) $display("FAIL stall_xfers: got %0d expected 4", xfers); else pass_cnt++;
    total_cnt++; if (vo_word_q.size() !== 10) $display("FAIL stall_valid_cycles: got %0d expected 10", vo_word_q.size()); else pass_cnt++;
    total_cnt++; if (checksum !== exp_cs) $display("FAIL stall_checksum: got %h expected %h", checksum, exp_cs); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL stall_done: got %b expected 1", done); else pass_cnt++;
  endtask

  task automatic test_bad_id();
    logic [63:0] exp_cs;
    int bad;
    reply_q.delete();
    exp_cs = '0;
    bad = $urandom_range(3, 0);
    for (int i = 0; i < 4; i++) begin
      reply_q.push_back(mk_reply((i == bad) ? 4'h3 : 4'(CID), 11'd0, rand64()));
      exp_cs ^= reply_q[i].payload;
    end
    drive_run(0, 4, 2, -1);
    total_cnt++; if (error !== 1'b1) $display("FAIL badid_error: got %b expected 1", error); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL badid_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (err_fell !== 1'b0) $display("FAIL badid_sticky: got %b expected 0", err_fell); else pass_cnt++;
    total_cnt++; if (end_cyc !== last_reply_cyc) $display("FAIL badid_end_cycle: got %0d expected %0d", end_cyc, last_reply_cyc); else pass_cnt++;
    total_cnt++; if (checksum !== exp_cs) $display("FAIL badid_checksum: got %h expected %h", checksum, exp_cs); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (error !== 1'b1) $display("FAIL badid_hold: got %b expected 1", error); else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic [63:0] exp_cs;
    reply_q.delete();
    drive_run(0, 0, 0, -1);
    total_cnt++; if (end_cyc !== 11) $display("FAIL timeout_cycle: got %0d expected 11", end_cyc); else pass_cnt++;
    total_cnt++; if (error !== 1'b1) $display("FAIL timeout_error: got %b expected 1", error); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL timeout_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (link.en_o !== 1'b0) $display("FAIL timeout_en: got %b expected 0", link.en_o); else pass_cnt++;
    total_cnt++; if (checksum !== 64'd0) $display("FAIL timeout_checksum: got %h expected 0", checksum); else pass_cnt++;
    // Two replies then silence: the timer restarts from the last reply.
    exp_cs = '0;
    for (int i = 0; i < 2; i++) begin
      reply_q.push_back(mk_reply(4'(CID), 11'd0, rand64()));
      exp_cs ^= reply_q[i].payload;
    end
    drive_run(0, 4, 0, -1);
    total_cnt++; if (end_cyc !== 13) $display("FAIL timeout_partial_cycle: got %0d expected 13", end_cyc); else pass_cnt++;
    total_cnt++; if (error !== 1'b1) $display("FAIL timeout_partial_error: got %b expected 1", error); else pass_cnt++;
    total_cnt++; if (checksum !== exp_cs) $display("FAIL timeout_partial_checksum: got %h expected %h", checksum, exp_cs); else pass_cnt++;
  endtask

  task automatic test_reset_mid_send();
    logic [63:0] p;
    logic [63:0] exp_cs;
    int xfers;
    p = rand64() | 64'd1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    link.ready_i = 1'b1; link.v_i = 1'b1; link.data_i = mk_reply(4'(CID), 11'd0, p);
    @(posedge clk); #1 link.v_i = 1'b0; link.data_i = '0;
    @(posedge clk); #1 link.ready_i = 1'b0;
    @(negedge clk);
    total_cnt++; if (link.data_o !== exp_word(2)) $display("FAIL rst_mid_word2: got %h expected %h", link.data_o, exp_word(2)); else pass_cnt++;
    total_cnt++; if (checksum !== p) $display("FAIL rst_mid_pre_checksum: got %h expected %h", checksum, p); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (link.v_o !== 1'b0) $display("FAIL rst_mid_v: got %b expected 0", link.v_o); else pass_cnt++;
    total_cnt++; if (link.en_o !== 1'b0) $display("FAIL rst_mid_en: got %b expected 0", link.en_o); else pass_cnt++;
    total_cnt++; if (checksum !== 64'd0) $display("FAIL rst_mid_checksum: got %h expected 0", checksum); else pass_cnt++;
    total_cnt++; if (link.data_o !== '0) $display("FAIL rst_mid_data: got %h expected 0", link.data_o); else pass_cnt++;
    @(negedge clk); reset_n = 1'b1;
    reply_q.delete();
    exp_cs = '0;
    for (int i = 0; i < 4; i++) begin
      reply_q.push_back(mk_reply(4'(CID), 11'd0, rand64()));
      exp_cs ^= reply_q[i].payload;
    end
    drive_run(2, 6, 2, -1);
    xfers = 0;
    foreach (vo_word_q[i]) begin
      total_cnt++;
      if (vo_word_q[i] !== exp_word(xfers)) $display("FAIL rst_rerun_word_cyc%0d: got %h expected %h", vo_cyc_q[i], vo_word_q[i], exp_word(xfers));
      else pass_cnt++;
      if (vo_rdy_q[i]) xfers++;
    end
    total_cnt++; if (xfers !== 4) $display("FAIL rst_rerun_xfers: got %0d expected 4", xfers); else pass_cnt++;
    total_cnt++; if (checksum !== exp_cs) $display("FAIL rst_rerun_checksum: got %h expected %h", checksum, exp_cs); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL rst_rerun_done: got %b expected 1", done); else pass_cnt++;
  endtask

  task automatic test_stray_start();
    logic [63:0] exp_cs;
    int xfers;
    for (int run = 0; run < 2; run++) begin
      reply_q.delete();
      exp_cs = '0;
      for (int i = 0; i < 4; i++) begin
        reply_q.push_back(mk_reply(4'(CID), 11'd0, rand64()));
        exp_cs ^= reply_q[i].payload;
      end
      // Run 0: stray start during RECV. Run 1: stray start while stalled in SEND, launched from DONE.
      if (run == 0) drive_run(0, 6, 1, 5);
      else          drive_run(1, 11, 1, 1);
      xfers = 0;
      foreach (vo_word_q[i]) begin
        total_cnt++;
        if (vo_word_q[i] !== exp_word(xfers)) $display("FAIL stray%0d_word_cyc%0d: got %h expected %h", run, vo_cyc_q[i], vo_word_q[i], exp_word(xfers));
        else pass_cnt++;
        if (vo_rdy_q[i]) xfers++;
      end
      total_cnt++; if (xfers !== 4) $display("FAIL stray%0d_xfers: got %0d expected 4", run, xfers); else pass_cnt++;
      total_cnt++; if (checksum !== exp_cs) $display("FAIL stray%0d_checksum: got %h expected %h", run, checksum, exp_cs); else pass_cnt++;
      total_cnt++; if (done !== 1'b1) $display("FAIL stray%0d_done: got %b expected 1", run, done); else pass_cnt++;
      total_cnt++; if (end_cyc !== last_reply_cyc) $display("FAIL stray%0d_end_cycle: got %0d expected %0d", run, end_cyc, last_reply_cyc); else pass_cnt++;
    end
  endtask

  task automatic test_drop();
    logic [63:0] cs_before;
    cs_before = checksum;
    @(posedge clk); #1;
    link.v_i    = 1'b1;
    link.data_i = mk_reply(4'h7, 11'd1, rand64() | 64'd1);
    @(negedge clk);
    total_cnt++; if (link.yumi_o !== 1'b1) $display("FAIL drop_yumi: got %b expected 1", link.yumi_o); else pass_cnt++;
    @(posedge clk); #1;
    link.v_i    = 1'b0;
    link.data_i = '0;
    total_cnt++; if (checksum !== cs_before) $display("FAIL drop_checksum: got %h expected %h", checksum, cs_before); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL drop_error: got %b expected 0", error); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL drop_done: got %b expected 1", done); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [63:0] exp_cs;
    bit exp_err;
    int xfers;
    int last_xfer;
    int exp_end;
    for (int it = 0; it < 8; it++) begin
      reply_q.delete();
      exp_cs  = '0;
      exp_err = 1'b0;
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(9, 0))
          0:       begin reply_q.push_back(mk_reply(4'($urandom_range(15, 1)), 11'd0, rand64())); exp_err = 1'b1; end
          1:       begin reply_q.push_back(mk_reply(4'(CID), 11'($urandom_range(2047, 1)), rand64())); exp_err = 1'b1; end
          default: reply_q.push_back(mk_reply(4'(CID), 11'd0, rand64()));
        endcase
        exp_cs ^= reply_q[i].payload;
      end
      drive_run(2, $urandom_range(10, 0), $urandom_range(3, 0), -1);
      xfers     = 0;
      last_xfer = -1;
      foreach (vo_word_q[i]) begin
        total_cnt++;
        if (vo_word_q[i] !== exp_word(xfers)) $display("FAIL rand%0d_word_cyc%0d: got %h expected %h", it, vo_cyc_q[i], vo_word_q[i], exp_word(xfers));
        else pass_cnt++;
        if (vo_rdy_q[i]) begin
          xfers++;
          last_xfer = vo_cyc_q[i];
        end
      end
      exp_end = (last_reply_cyc > last_xfer + 1) ? last_reply_cyc : last_xfer + 1;
      total_cnt++; if (xfers !== 4) $display("FAIL rand%0d_xfers: got %0d expected 4", it, xfers); else pass_cnt++;
      total_cnt++; if (checksum !== exp_cs) $display("FAIL rand%0d_checksum: got %h expected %h", it, checksum, exp_cs); else pass_cnt++;
      total_cnt++; if (error !== exp_err) $display("FAIL rand%0d_error: got %b expected %b", it, error, exp_err); else pass_cnt++;
      total_cnt++; if (done !== !exp_err) $display("FAIL rand%0d_done: got %b expected %b", it, done, !exp_err); else pass_cnt++;
      total_cnt++; if (end_cyc !== exp_end) $display("FAIL rand%0d_end_cycle: got %0d expected %0d", it, end_cyc, exp_end); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bad_id();
    test_timeout();
    test_reset_mid_send();
    test_stray_start();
    test_drop();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
